// File: rtl/xbar_pkg.sv
// Shared widths and column-arbiter state for the buffered round-robin crossbar.
package xbar_pkg;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int sel_w(input int out_num);
    return clog2_min1(out_num);
  endfunction

  function automatic int src_w(input int in_num);
    return clog2_min1(in_num);
  endfunction

  function automatic int qsel_w(input int prio_w, input int dport_w);
    return prio_w + dport_w;
  endfunction

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } col_state_e;

endpackage

// File: rtl/xbar_xp_fifo.sv
// Crosspoint FWFT FIFO with registered full/empty flags.
module xbar_xp_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp, rp;
  logic [AW:0]      cnt, cnt_nxt;
  logic             push, pop;

  assign push    = i_push & ~o_full;
  assign pop     = i_pop & ~o_empty;
  assign cnt_nxt = cnt + (AW+1)'(push) - (AW+1)'(pop);
  assign o_data  = mem[rp];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wp      <= '0;
      rp      <= '0;
      cnt     <= '0;
      o_full  <= 1'b0;
      o_empty <= 1'b1;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      cnt    <= cnt_nxt;
      o_full <= (cnt_nxt == (AW+1)'(DEPTH));
      // A push becomes visible one edge later; a pop to empty is seen at once.
      o_empty <= ((cnt - (AW+1)'(pop)) == '0);
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wp] <= i_data;
  end

endmodule

// File: rtl/xbar_rr_fabric.sv
// IN_NUM x OUT_NUM buffered crossbar: per-crosspoint FIFOs, per-column
// round-robin arbiter with optional packet lock and ready/valid output.
module xbar_rr_fabric
  import xbar_pkg::*;
#(
  parameter int IN_NUM     = 4,
  parameter int OUT_NUM    = 4,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int PKT_MODE   = 0,
  parameter int PRIO_LSB   = 4,
  parameter int PRIO_W     = 3,
  parameter int DPORT_W    = 2,
  localparam int SEL_W     = sel_w(OUT_NUM),
  localparam int SRC_W     = src_w(IN_NUM),
  localparam int QSEL_W    = qsel_w(PRIO_W, DPORT_W)
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [IN_NUM*DATA_W-1:0]    i_din,
  input  logic [IN_NUM*SEL_W-1:0]     i_sel,
  input  logic [IN_NUM-1:0]           i_wr_en,
  input  logic [IN_NUM-1:0]           i_last,
  output logic [IN_NUM-1:0]           o_ready,
  output logic [IN_NUM-1:0]           o_drop,
  output logic [OUT_NUM*DATA_W-1:0]   o_dout,
  output logic [OUT_NUM*QSEL_W-1:0]   o_queue_sel,
  output logic [OUT_NUM*SRC_W-1:0]    o_src,
  output logic [OUT_NUM-1:0]          o_last,
  output logic [OUT_NUM-1:0]          o_valid,
  input  logic [OUT_NUM-1:0]          i_ready
);
  localparam int FW = DATA_W + 1;

  logic [IN_NUM-1:0][OUT_NUM-1:0]         xp_full, xp_empty, xp_push;
  logic [OUT_NUM-1:0][IN_NUM-1:0]         xp_pop;
  logic [IN_NUM-1:0][OUT_NUM-1:0][FW-1:0] xp_dout;
  logic [IN_NUM-1:0]                      ready_c, drop_q;

  // Ingress: route each line to its addressed crosspoint row.
  for (genvar n = 0; n < IN_NUM; n++) begin : g_line
    logic [SEL_W-1:0]        sel;
    logic [(1<<SEL_W)-1:0]   full_pad;
    logic [FW-1:0]           word;

    assign sel  = i_sel[n*SEL_W +: SEL_W];
    assign word = {i_last[n] & (PKT_MODE != 0), i_din[n*DATA_W +: DATA_W]};

    // Nonexistent columns read as full so they are never accepted.
    always_comb begin
      full_pad              = '1;
      full_pad[OUT_NUM-1:0] = xp_full[n];
    end

    assign ready_c[n] = ~full_pad[sel] & ~i_rst;

    for (genvar m = 0; m < OUT_NUM; m++) begin : g_xp
      assign xp_push[n][m] = i_wr_en[n] & ready_c[n] & (sel == SEL_W'(m));

      xbar_xp_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_xp (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (xp_push[n][m]),
        .i_data  (word),
        .i_pop   (xp_pop[m][n]),
        .o_data  (xp_dout[n][m]),
        .o_full  (xp_full[n][m]),
        .o_empty (xp_empty[n][m])
      );
    end
  end

  assign o_ready = ready_c;
  assign o_drop  = drop_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) drop_q <= '0;
    else       drop_q <= i_wr_en & ~ready_c;
  end

  // Egress: one arbiter + output register per column.
  for (genvar m = 0; m < OUT_NUM; m++) begin : g_col
    col_state_e        st_q, st_d;
    logic [SRC_W-1:0]  ptr_q, ptr_d, lock_q, lock_d;
    logic [SRC_W-1:0]  gnt, gnt_lo, gnt_hi, gnt_inc, lock_inc;
    logic [IN_NUM-1:0] req;
    logic              gnt_vld, hi_vld, ld, fire;
    logic [FW-1:0]     gword;
    logic [DATA_W-1:0] dout_q;
    logic [QSEL_W-1:0] qsel_q;
    logic [SRC_W-1:0]  src_q;
    logic              last_q, vld_q;

    // In LOCK only the locked source may request.
    always_comb begin
      for (int n = 0; n < IN_NUM; n++)
        req[n] = ~xp_empty[n][m] & ((st_q == ST_IDLE) | (lock_q == SRC_W'(n)));
    end

    always_comb begin
      gnt_lo  = '0;
      gnt_hi  = '0;
      hi_vld  = 1'b0;
      gnt_vld = |req;
      for (int n = IN_NUM-1; n >= 0; n--) begin
        if (req[n]) gnt_lo = SRC_W'(n);
        if (req[n] && (SRC_W'(n) >= ptr_q)) begin
          gnt_hi = SRC_W'(n);
          hi_vld = 1'b1;
        end
      end
      gnt = hi_vld ? gnt_hi : gnt_lo;
    end

    always_comb begin
      gword = '0;
      for (int n = 0; n < IN_NUM; n++)
        if (gnt == SRC_W'(n)) gword = xp_dout[n][m];
    end

    assign ld       = ~vld_q | i_ready[m];
    assign fire     = ld & gnt_vld;
    assign gnt_inc  = (gnt == SRC_W'(IN_NUM-1)) ? '0 : gnt + SRC_W'(1);
    assign lock_inc = (lock_q == SRC_W'(IN_NUM-1)) ? '0 : lock_q + SRC_W'(1);
    assign xp_pop[m] = fire ? (IN_NUM'(1) << gnt) : '0;

    always_comb begin
      st_d   = st_q;
      ptr_d  = ptr_q;
      lock_d = lock_q;
      if (fire) begin
        if (PKT_MODE == 0) begin
          ptr_d = gnt_inc;
        end else begin
          case (st_q)
            ST_IDLE: begin
              if (gword[DATA_W]) begin
                ptr_d = gnt_inc;
              end else begin
                st_d   = ST_LOCK;
                lock_d = gnt;
              end
            end
            ST_LOCK: begin
              if (gword[DATA_W]) begin
                st_d  = ST_IDLE;
                ptr_d = lock_inc;
              end
            end
            default: st_d = ST_IDLE;
          endcase
        end
      end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        st_q   <= ST_IDLE;
        ptr_q  <= '0;
        lock_q <= '0;
      end else begin
        st_q   <= st_d;
        ptr_q  <= ptr_d;
        lock_q <= lock_d;
      end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        vld_q  <= 1'b0;
        dout_q <= '0;
        qsel_q <= '0;
        src_q  <= '0;
        last_q <= 1'b0;
      end else if (ld) begin
        vld_q <= gnt_vld;
        if (gnt_vld) begin
          dout_q <= gword[DATA_W-1:0];
          qsel_q <= {gword[PRIO_LSB+PRIO_W-1:PRIO_LSB], gword[DPORT_W-1:0]};
          src_q  <= gnt;
          last_q <= gword[DATA_W];
        end
      end
    end

    assign o_dout[m*DATA_W +: DATA_W]      = dout_q;
    assign o_queue_sel[m*QSEL_W +: QSEL_W] = qsel_q;
    assign o_src[m*SRC_W +: SRC_W]         = src_q;
    assign o_last[m]                       = last_q;
    assign o_valid[m]                      = vld_q;
  end

endmodule

// File: tb/tb_xbar_rr_fabric.sv
// Scoreboard bench: dut0 is 4x4 per-word, dut1 is 4x3 per-packet.
module tb_xbar_rr_fabric;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  src;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst0, rst1;
  logic [127:0] din0, din1;
  logic [7:0]   sel0, sel1;
  logic [3:0]   wr0, last0, rdy0, drop0;
  logic [3:0]   wr1, last1, rdy1, drop1;
  logic [127:0] dout0;
  logic [19:0]  qsel0;
  logic [7:0]   src0;
  logic [3:0]   olast0, ovld0, irdy0;
  logic [95:0]  dout1;
  logic [14:0]  qsel1;
  logic [5:0]   src1;
  logic [2:0]   olast1, ovld1, irdy1;

  int n_tests = 0;
  int n_fail  = 0;
  exp_t sbq[$];
  logic [31:0] lq[4][$];

  xbar_rr_fabric #(.IN_NUM(4), .OUT_NUM(4), .PKT_MODE(0)) dut0 (
    .i_clk(clk), .i_rst(rst0), .i_din(din0), .i_sel(sel0), .i_wr_en(wr0),
    .i_last(last0), .o_ready(rdy0), .o_drop(drop0), .o_dout(dout0),
    .o_queue_sel(qsel0), .o_src(src0), .o_last(olast0), .o_valid(ovld0),
    .i_ready(irdy0));

  xbar_rr_fabric #(.IN_NUM(4), .OUT_NUM(3), .PKT_MODE(1)) dut1 (
    .i_clk(clk), .i_rst(rst1), .i_din(din1), .i_sel(sel1), .i_wr_en(wr1),
    .i_last(last1), .o_ready(rdy1), .o_drop(drop1), .o_dout(dout1),
    .o_queue_sel(qsel1), .o_src(src1), .o_last(olast1), .o_valid(ovld1),
    .i_ready(irdy1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    n_tests++; if (ovld0 !== '0 || ovld1 !== '0) begin n_fail++; $display("FAIL rst_valid: got %h/%h want 0", ovld0, ovld1); end
    n_tests++; if (dout0 !== '0 || dout1 !== '0) begin n_fail++; $display("FAIL rst_dout: got %h/%h want 0", dout0, dout1); end
    n_tests++; if (qsel0 !== '0 || src0 !== '0 || olast0 !== '0) begin n_fail++; $display("FAIL rst_meta: got %h %h %h want 0", qsel0, src0, olast0); end
    n_tests++; if (rdy0 !== '0 || rdy1 !== '0) begin n_fail++; $display("FAIL rst_ready: got %h/%h want 0", rdy0, rdy1); end
    n_tests++; if (drop0 !== '0 || drop1 !== '0) begin n_fail++; $display("FAIL rst_drop: got %h/%h want 0", drop0, drop1); end
    rst0 = 1'b0;
    rst1 = 1'b0;
    tick();
    n_tests++; if (rdy0 !== 4'hf) begin n_fail++; $display("FAIL post_rst_ready: got %h want f", rdy0); end
  endtask

  task automatic test_single();
    exp_t e;
    sel0[5:4] = 2'd1;
    din0[95:64] = 32'h0000_0053;
    wr0 = 4'b0100;
    sbq.push_back('{d: 32'h53, src: 2'd2, last: 1'b0});
    tick();
    wr0 = '0;
    n_tests++; if (ovld0 !== 4'b0000) begin n_fail++; $display("FAIL single_lat1: got %b want 0000", ovld0); end
    tick();
    n_tests++; if (ovld0 !== 4'b0000) begin n_fail++; $display("FAIL single_lat2: got %b want 0000", ovld0); end
    tick();
    n_tests++; if (ovld0 !== 4'b0010) begin n_fail++; $display("FAIL single_valid: got %b want 0010", ovld0); end
    e = sbq.pop_front();
    n_tests++; if (dout0[63:32] !== e.d) begin n_fail++; $display("FAIL single_data: got %h want %h", dout0[63:32], e.d); end
    n_tests++; if (src0[3:2] !== e.src) begin n_fail++; $display("FAIL single_src: got %0d want %0d", src0[3:2], e.src); end
    n_tests++; if (qsel0[9:5] !== 5'b10111) begin n_fail++; $display("FAIL single_qsel: got %b want 10111", qsel0[9:5]); end
    n_tests++; if (olast0[1] !== e.last) begin n_fail++; $display("FAIL single_last: got %b want %b", olast0[1], e.last); end
    tick();
    n_tests++; if (ovld0 !== 4'b0000) begin n_fail++; $display("FAIL single_clear: got %b want 0000", ovld0); end
  endtask

  task automatic test_fairness();
    int got = 0, first = -1, lastc = -1, exp_src = 0;
    logic [31:0] e;
    sel0 = '0;
    for (int c = 0; c < 200 && got < 64; c++) begin
      if (c < 16) begin
        for (int l = 0; l < 4; l++) begin
          din0[l*32 +: 32] = {8'(l), 24'(c)};
          lq[l].push_back({8'(l), 24'(c)});
        end
        n_tests++; if (rdy0 !== 4'hf) begin n_fail++; $display("FAIL fair_ready: got %h want f", rdy0); end
        wr0 = 4'hf;
      end else begin
        wr0 = '0;
      end
      tick();
      if (ovld0[0]) begin
        if (first < 0) first = c;
        lastc = c;
        got++;
        e = (lq[exp_src].size() > 0) ? lq[exp_src].pop_front() : 32'hxxxx_xxxx;
        n_tests++; if (src0[1:0] !== 2'(exp_src)) begin n_fail++; $display("FAIL fair_src: got %0d want %0d", src0[1:0], exp_src); end
        n_tests++; if (dout0[31:0] !== e) begin n_fail++; $display("FAIL fair_data: got %h want %h", dout0[31:0], e); end
        exp_src = (exp_src + 1) % 4;
      end
    end
    wr0 = '0;
    n_tests++; if (got !== 64 || (lastc - first) !== 63) begin n_fail++; $display("FAIL fair_gap: got %0d words over %0d cycles want 64 over 64", got, lastc - first + 1); end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int got = 0;
    irdy0[3] = 1'b0;
    sel0[1:0] = 2'd3;
    #1;
    for (int k = 0; k < 17; k++) begin
      din0[31:0] = 32'hB000_0000 + 32'(k);
      sbq.push_back('{d: 32'hB000_0000 + 32'(k), src: 2'd0, last: 1'b0});
      n_tests++; if (rdy0[0] !== 1'b1) begin n_fail++; $display("FAIL bp_accept: word %0d ready got %b want 1", k, rdy0[0]); end
      wr0[0] = 1'b1;
      tick();
    end
    wr0[0] = 1'b0;
    tick();
    n_tests++; if (rdy0[0] !== 1'b0) begin n_fail++; $display("FAIL bp_full: ready got %b want 0", rdy0[0]); end
    n_tests++; if (ovld0[3] !== 1'b1 || dout0[127:96] !== 32'hB000_0000) begin n_fail++; $display("FAIL bp_hold: got v=%b d=%h want v=1 d=b0000000", ovld0[3], dout0[127:96]); end
    din0[31:0] = 32'hDEAD_BEEF;
    wr0[0] = 1'b1;
    tick();
    wr0[0] = 1'b0;
    n_tests++; if (drop0 !== 4'b0001) begin n_fail++; $display("FAIL bp_drop: got %b want 0001", drop0); end
    tick();
    n_tests++; if (drop0 !== 4'b0000) begin n_fail++; $display("FAIL bp_drop_pulse: got %b want 0000", drop0); end
    n_tests++; if (dout0[127:96] !== 32'hB000_0000) begin n_fail++; $display("FAIL bp_stable: got %h want b0000000", dout0[127:96]); end
    irdy0[3] = 1'b1;
    for (int c = 0; c < 60 && sbq.size() > 0; c++) begin
      if (ovld0[3]) begin
        e = sbq.pop_front();
        got++;
        n_tests++; if (dout0[127:96] !== e.d || src0[7:6] !== e.src) begin n_fail++; $display("FAIL bp_order: got %h/%0d want %h/%0d", dout0[127:96], src0[7:6], e.d, e.src); end
      end
      tick();
    end
    n_tests++; if (got !== 17) begin n_fail++; $display("FAIL bp_count: got %0d want 17", got); end
    n_tests++; if (ovld0[3] !== 1'b0) begin n_fail++; $display("FAIL bp_no_extra: valid got %b want 0", ovld0[3]); end
    sbq.delete();
  endtask

  task automatic collect1(input int col, input string name, output int first, output int lastc);
    exp_t e;
    first = -1;
    lastc = -1;
    for (int c = 0; c < 40 && sbq.size() > 0; c++) begin
      if (ovld1[col]) begin
        e = sbq.pop_front();
        if (first < 0) first = c;
        lastc = c;
        n_tests++;
        if (dout1[col*32 +: 32] !== e.d || src1[col*2 +: 2] !== e.src || olast1[col] !== e.last) begin
          n_fail++;
          $display("FAIL %s: got %h/%0d/%b want %h/%0d/%b", name, dout1[col*32 +: 32], src1[col*2 +: 2], olast1[col], e.d, e.src, e.last);
        end
      end
      tick();
    end
    n_tests++; if (sbq.size() !== 0) begin n_fail++; $display("FAIL %s_timeout: %0d words missing want 0", name, sbq.size()); end
    sbq.delete();
  endtask

  task automatic test_packet();
    int f, l;
    irdy1 = 3'b111;
    sel1[3:2] = 2'd2;
    sel1[7:6] = 2'd2;
    din1[63:32] = 32'h1100_0000; din1[127:96] = 32'h3300_0000; last1 = 4'b0000; wr1 = 4'b1010;
    tick();
    din1[63:32] = 32'h1100_0001; din1[127:96] = 32'h3300_0001; last1 = 4'b1000;
    tick();
    din1[63:32] = 32'h1100_0002; last1 = 4'b0010; wr1 = 4'b0010;
    tick();
    wr1 = '0; last1 = '0;
    sbq.push_back('{d: 32'h1100_0000, src: 2'd1, last: 1'b0});
    sbq.push_back('{d: 32'h1100_0001, src: 2'd1, last: 1'b0});
    sbq.push_back('{d: 32'h1100_0002, src: 2'd1, last: 1'b1});
    sbq.push_back('{d: 32'h3300_0000, src: 2'd3, last: 1'b0});
    sbq.push_back('{d: 32'h3300_0001, src: 2'd3, last: 1'b1});
    collect1(2, "pkt_word", f, l);
    n_tests++; if ((l - f) !== 4) begin n_fail++; $display("FAIL pkt_contig: span got %0d want 4", l - f); end
    // Pointer back at 0 means line 0 wins over line 3.
    sel1[1:0] = 2'd2;
    din1[31:0] = 32'h0A00_0000; din1[127:96] = 32'h3A00_0000; last1 = 4'b1001; wr1 = 4'b1001;
    tick();
    wr1 = '0; last1 = '0;
    sbq.push_back('{d: 32'h0A00_0000, src: 2'd0, last: 1'b1});
    sbq.push_back('{d: 32'h3A00_0000, src: 2'd3, last: 1'b1});
    collect1(2, "pkt_ptr", f, l);
  endtask

  task automatic test_reset_lock();
    int f, l;
    bool_wait: begin end
    irdy1[1] = 1'b0;
    sel1[3:2] = 2'd1;
    din1[63:32] = 32'h5500_0000; last1 = 4'b0000; wr1 = 4'b0010;
    tick();
    din1[63:32] = 32'h5500_0001;
    tick();
    wr1 = '0;
    for (int c = 0; c < 10 && !ovld1[1]; c++) tick();
    n_tests++; if (ovld1[1] !== 1'b1) begin n_fail++; $display("FAIL rl_lock_valid: got %b want 1", ovld1[1]); end
    #2;
    rst1 = 1'b1;
    #1;
    n_tests++; if (ovld1 !== '0 || dout1 !== '0) begin n_fail++; $display("FAIL rl_async: got v=%b d=%h want 0", ovld1, dout1); end
    n_tests++; if (qsel1 !== '0 || src1 !== '0 || olast1 !== '0 || rdy1 !== '0) begin n_fail++; $display("FAIL rl_async_meta: got %h %h %b %h want 0", qsel1, src1, olast1, rdy1); end
    tick();
    rst1 = 1'b0;
    irdy1 = 3'b111;
    sel1[5:4] = 2'd1;
    din1[95:64] = 32'h2200_0057; last1 = 4'b0100; wr1 = 4'b0100;
    #1;
    tick();
    wr1 = '0; last1 = '0;
    n_tests++; if (ovld1 !== 3'b000) begin n_fail++; $display("FAIL rl_lat1: got %b want 000", ovld1); end
    tick();
    n_tests++; if (ovld1 !== 3'b000) begin n_fail++; $display("FAIL rl_lat2: got %b want 000", ovld1); end
    tick();
    n_tests++; if (ovld1 !== 3'b010) begin n_fail++; $display("FAIL rl_valid: got %b want 010", ovld1); end
    n_tests++; if (qsel1[9:5] !== 5'b10111) begin n_fail++; $display("FAIL rl_qsel: got %b want 10111", qsel1[9:5]); end
    sbq.push_back('{d: 32'h2200_0057, src: 2'd2, last: 1'b1});
    collect1(1, "rl_word", f, l);
    n_tests++; if (ovld1 !== 3'b000) begin n_fail++; $display("FAIL rl_flushed: got %b want 000", ovld1); end
  endtask

  task automatic test_bad_sel();
    int seen = 0;
    sel1[1:0] = 2'd3;
    din1[31:0] = 32'hBAD0_0001; last1 = 4'b0001; wr1 = 4'b0001;
    tick();
    wr1 = '0; last1 = '0;
    n_tests++; if (drop1 !== 4'b0001) begin n_fail++; $display("FAIL bad_drop: got %b want 0001", drop1); end
    for (int c = 0; c < 5; c++) begin
      tick();
      if (ovld1 !== 3'b000) seen++;
    end
    n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL bad_no_output: %0d cycles valid want 0", seen); end
    n_tests++; if (drop1 !== 4'b0000) begin n_fail++; $display("FAIL bad_drop_pulse: got %b want 0000", drop1); end
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    din0 = '0; sel0 = '0; wr0 = '0; last0 = '0; irdy0 = 4'hf;
    din1 = '0; sel1 = '0; wr1 = '0; last1 = '0; irdy1 = 3'h7;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_packet();
    test_reset_lock();
    test_bad_sel();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/xbar_rr_fabric.md
# xbar_rr_fabric

Parametrised IN_NUM x OUT_NUM buffered crossbar between the ingress dispatch stage and the per-port priority queue writers of the shared buffer. Each crosspoint has its own FIFO. Each output column has a round-robin arbiter with ready/valid backpressure, so a column can sustain one word per cycle. An optional packet mode holds a column's grant until the end of the packet.

## Interface
- IN_NUM, 4: input lines (2..16)
- OUT_NUM, 4: output columns (2..16); SEL_W = max(1, $clog2(OUT_NUM)), SRC_W = max(1, $clog2(IN_NUM))
- DATA_W, 32: word width
- FIFO_DEPTH, 16: words per crosspoint FIFO, power of two, >= 2
- PKT_MODE, 0: 0 = per-word arbitration, 1 = per-packet arbitration
- PRIO_LSB, 4 / PRIO_W, 3: priority field position and width inside the word
- DPORT_W, 2: destination-port field width, taken from word bits [DPORT_W-1:0]
- i_clk  in  1  sole clock
- i_rst  in  1  asynchronous, active-high reset
- i_din  in  IN_NUM*DATA_W  line data, line n at slice n
- i_sel  in  IN_NUM*SEL_W  destination column per line
- i_wr_en  in  IN_NUM  write strobe per line
- i_last  in  IN_NUM  last word of packet (ignored when PKT_MODE=0)
- o_ready  out  IN_NUM  addressed crosspoint FIFO not full
- o_drop  out  IN_NUM  1-cycle pulse: i_wr_en while !o_ready, or i_sel >= OUT_NUM
- o_dout  out  OUT_NUM*DATA_W  column data
- o_queue_sel  out  OUT_NUM*(PRIO_W+DPORT_W)  {prio, dest_port} of o_dout
- o_src  out  OUT_NUM*SRC_W  input line that sourced o_dout
- o_last  out  OUT_NUM  last flag of o_dout
- o_valid  out  OUT_NUM  column word valid
- i_ready  in  OUT_NUM  downstream accepts column word

## Operation
- Write: line n is accepted when i_wr_en[n] & o_ready[n]. {i_last, i_din} is pushed into crosspoint (n, i_sel[n]). An accepted word is never lost.
- o_ready[n] is the registered not-full flag of the FIFO addressed by the current i_sel[n]. A FIFO that is full cannot take a write, even in a cycle where the same FIFO is popped.
- Crosspoint FIFO is first-word-fall-through. Indexing: FIFO (line n, column m).
- Column m output register load condition: ld = !o_valid[m] | i_ready[m].
- Column m arbiter works on req[n] = !empty(n,m). On ld & |req it grants the first requester at or after ptr[m], wrapping modulo IN_NUM. It pops that FIFO and loads o_dout, o_queue_sel = {word[PRIO_LSB+PRIO_W-1:PRIO_LSB], word[DPORT_W-1:0]}, o_src, o_last, and sets o_valid=1.
- If ld and no request, o_valid[m] clears to 0.
- PKT_MODE=0: after each grant, ptr[m] = grant+1 (wrapping).
- PKT_MODE=1: per-column FSM.
  - IDLE: on grant of a word with last=0, go to LOCK(src) and hold ptr.
  - In IDLE, a word with last=1 is a single-word packet: ptr = grant+1.
  - LOCK: only src may be popped, and other requesters are masked. Popping a last=1 word sets ptr = src+1 and returns to IDLE.
  - While src is empty in LOCK, the column idles (o_valid drops) and the lock is held.
- Columns are fully independent. All OUT_NUM columns may pop in the same cycle.

## Timing
- Reset values: o_valid=0, o_dout=0, o_queue_sel=0, o_src=0, o_last=0, o_drop=0, o_ready=0 while i_rst is high. All FIFOs are empty, ptr=0, FSMs are IDLE.
- Write-to-output latency: word accepted at edge t shows o_valid at edge t+2 (FIFO flag update, then output register), given no contention.
- Column throughput: 1 word/cycle while i_ready=1 and requests are pending.
- o_valid/o_dout are held stable while o_valid & !i_ready.
- o_ready reflects a pop at edge t from cycle t+1 onward.
- o_drop is registered: it asserts one cycle after the rejected strobe.
- Reset asserted mid-packet: FIFOs are flushed, LOCK is abandoned, and outputs return to reset values asynchronously.

## Structure
- Shared package xbar_pkg: index/width helper constants (SEL_W, SRC_W, QSEL_W), column FSM state enum (ST_IDLE, ST_LOCK).
- Sub-module xbar_xp_fifo: DATA_W+1 wide FWFT synchronous FIFO with registered full/empty, same reset. Instantiated IN_NUM*OUT_NUM times in a generate loop.
- Arbiter and output register sit inline, one generate block per column.

## Test plan
- Single word: line 2 writes 0x0000_0053 to column 1. Column 1 o_valid rises 2 cycles later with o_src=2 and o_queue_sel={3'b101,2'b11}. Other columns stay idle.
- Fairness (PKT_MODE=0): all 4 lines stream to column 0 continuously with i_ready=1. Column 0 grant order is 0,1,2,3,0,..., one word per cycle, no gaps.
- Backpressure: hold i_ready[3]=0 with 17 words queued from line 0 to column 3 (16 in the FIFO, 1 in the output register). The 18th write is rejected: o_ready[0]=0 and o_drop[0] pulses. o_dout is held. After i_ready is released, the remaining 17 words arrive in order.
- Packet mode: line 1 sends a 3-word packet and line 3 sends a 2-word packet, both to column 2, interleaved at the inputs. The output carries contiguous packets: all of line 1's, then line 3's, with o_last on words 3 and 5. ptr ends at 0.
- Reset mid-stream: assert i_rst during a LOCK. All outputs go to 0 immediately. After release, a new single word flows with the 2-cycle latency.
- Bad select: OUT_NUM=3, i_sel=3 with i_wr_en. o_drop pulses and no column output occurs.
